mult_rr_scheduler: RTL and testbench

- Shares one 16x16 signed `booth_wallace_cla` multiplier instance, which is combinational, among NUM_REQ requesters.
- Arbitration is round-robin, with a valid/ready handshake on the request side and on the response side.
- Operands and product are registered around the multiplier, so its full combinational path gets a cycle of its own.
- Sits between DSP client blocks and the multiplier datapath; a single operation is in flight at any time.

---
 rtl/mult_rr_scheduler.sv | 157 +++++++++++++++
 tb/tb_mult_rr_scheduler.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_rr_scheduler.sv
// Round-robin scheduler sharing one registered 16x16 signed Booth multiplier
// among NUM_REQ requesters, with valid/ready handshakes on both sides.

module booth_wallace_cla (
  input  logic signed [15:0] i_a,
  input  logic signed [15:0] i_b,
  output logic signed [31:0] o_p
);
  // Radix-4 Booth recoding: each 3-bit window of {b,0} selects 0, +-a or +-2a.
  function automatic logic signed [31:0] booth_pp(input logic [2:0] dig,
                                                 input logic signed [31:0] ax);
    logic signed [31:0] pp;
    case (dig)
      3'b001, 3'b010: pp = ax;
      3'b011:         pp = ax <<< 1;
      3'b100:         pp = -(ax <<< 1);
      3'b101, 3'b110: pp = -ax;
      default:        pp = '0;
    endcase
    return pp;
  endfunction

  logic        [16:0] w_bx;
  logic signed [31:0] w_ax;
  logic signed [31:0] w_pp  [8];
  logic signed [31:0] w_sum [9];

  assign w_bx     = {i_b, 1'b0};
  assign w_ax     = {{16{i_a[15]}}, i_a};
  assign w_sum[0] = '0;

  for (genvar gj = 0; gj < 8; gj++) begin : g_pp
    assign w_pp[gj]      = booth_pp(w_bx[2*gj +: 3], w_ax) <<< (2*gj);
    assign w_sum[gj + 1] = w_sum[gj] + w_pp[gj];
  end

  assign o_p = w_sum[8];
endmodule

module mult_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [16*NUM_REQ-1:0]     req_a,
  input  logic [16*NUM_REQ-1:0]     req_b,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic signed [31:0]        resp_product,
  output logic [ID_W-1:0]           resp_id,
  output logic                      busy,
  output logic [15:0]               ops_done
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                    r_state, w_next;
  logic [ID_W-1:0]           r_ptr;
  logic signed [15:0]        r_a_p0, r_b_p0;
  logic [ID_W-1:0]           r_id_p0;
  logic signed [31:0]        r_prod_p1;
  logic [ID_W-1:0]           r_id_p1;
  logic                      r_vld_p1;
  logic [15:0]               r_ops;

  logic signed [15:0]        w_a [NUM_REQ];
  logic signed [15:0]        w_b [NUM_REQ];
  logic                      w_found;
  logic [ID_W-1:0]           w_grant, w_nptr;
  logic [ID_W:0]             w_cand;
  logic signed [31:0]        w_prod;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_a[gi] = req_a[16*gi +: 16];
    assign w_b[gi] = req_b[16*gi +: 16];
  end

  // First valid requester at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = {1'b0, r_ptr} + (ID_W+1)'(k);
      if (w_cand >= (ID_W+1)'(NUM_REQ)) w_cand = w_cand - (ID_W+1)'(NUM_REQ);
      if (!w_found && req_valid[w_cand[ID_W-1:0]]) begin
        w_found = 1'b1;
        w_grant = w_cand[ID_W-1:0];
      end
    end
  end

  assign w_nptr = (w_grant == ID_W'(NUM_REQ - 1)) ? '0 : w_grant + 1'b1;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_found) w_next = EXEC;
      EXEC:    w_next = RESP;
      RESP:    if (resp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign req_ready = (rst_n && r_state == IDLE && w_found)
                     ? (NUM_REQ'(1) << w_grant) : '0;

  booth_wallace_cla u_mult (
    .i_a (r_a_p0),
    .i_b (r_b_p0),
    .o_p (w_prod)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_a_p0    <= '0;
      r_b_p0    <= '0;
      r_id_p0   <= '0;
      r_prod_p1 <= '0;
      r_id_p1   <= '0;
      r_vld_p1  <= 1'b0;
      r_ops     <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        // p0: operand capture on grant
        IDLE: if (w_found) begin
          r_a_p0  <= w_a[w_grant];
          r_b_p0  <= w_b[w_grant];
          r_id_p0 <= w_grant;
          r_ptr   <= w_nptr;
        end
        // p1: product capture after a full cycle through the multiplier
        EXEC: begin
          r_prod_p1 <= w_prod;
          r_id_p1   <= r_id_p0;
          r_vld_p1  <= 1'b1;
        end
        RESP: if (resp_ready) begin
          r_vld_p1 <= 1'b0;
          r_ops    <= r_ops + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign resp_valid   = r_vld_p1;
  assign resp_product = r_prod_p1;
  assign resp_id      = r_id_p1;
  assign busy         = (r_state != IDLE);
  assign ops_done     = r_ops;
endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Bench for mult_rr_scheduler: vector table, scoreboard on every accept and
// response handshake, and sequences for fairness, backpressure and reset.

module tb_mult_rr_scheduler;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                  clk;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [16*NUM_REQ-1:0] req_a;
  logic [16*NUM_REQ-1:0] req_b;
  logic                  resp_valid;
  logic                  resp_ready;
  logic signed [31:0]    resp_product;
  logic [ID_W-1:0]       resp_id;
  logic                  busy;
  logic [15:0]           ops_done;

  mult_rr_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_product (resp_product),
    .resp_id      (resp_id),
    .busy         (busy),
    .ops_done     (ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] prod;
  } sb_t;

  typedef struct {
    int          rid;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   exp_ops = 0;
  sb_t  sb_q[$];
  int   acc_id_log[$];
  int   acc_cyc_log[$];

  always @(posedge clk) cyc++;

  function automatic void chk(input string nm, input logic [31:0] got,
                              input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endfunction

  function automatic void timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: wait expired", nm);
  endfunction

  // Scoreboard: reference product pushed at accept, compared at response.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (req_ready != '0) begin
        chk("ready_onehot", 32'($countones(req_ready)), 32'd1);
        chk("ready_has_valid", 32'(req_ready & ~req_valid), 32'd0);
        for (int i = 0; i < NUM_REQ; i++) begin
          if (req_ready[i]) begin
            int  ai, bi;
            sb_t e;
            ai = $signed(req_a[16*i +: 16]);
            bi = $signed(req_b[16*i +: 16]);
            e.id   = i;
            e.prod = 32'(ai * bi);
            sb_q.push_back(e);
            acc_id_log.push_back(i);
            acc_cyc_log.push_back(cyc);
          end
        end
      end
      if (resp_valid && resp_ready) begin
        if (sb_q.size() == 0) begin
          timeout("sb_unexpected_response");
        end else begin
          sb_t e;
          e = sb_q.pop_front();
          chk("sb_resp_id", 32'(resp_id), 32'(e.id));
          chk("sb_product", resp_product, e.prod);
        end
      end
    end
  end

  task automatic wait_ready(input int idx, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (req_ready[idx]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_resp(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (resp_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_drain(input string nm);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout(nm);
  endtask

  task automatic run_single(input vec_t v);
    bit ok;
    int acc;
    @(posedge clk); #1;
    req_a[16*v.rid +: 16] = v.a;
    req_b[16*v.rid +: 16] = v.b;
    req_valid[v.rid]      = 1'b1;
    wait_ready(v.rid, ok);
    if (!ok) begin
      timeout("single_accept");
      req_valid[v.rid] = 1'b0;
      return;
    end
    acc = cyc;
    @(posedge clk); #1;
    req_valid[v.rid] = 1'b0;
    wait_resp(ok);
    if (!ok) begin
      timeout("single_resp");
      return;
    end
    chk("latency", 32'(cyc - acc), 32'd2);
    chk("product", resp_product, v.exp);
    chk("resp_id", 32'(resp_id), 32'(v.rid));
    @(posedge clk); #1;
    exp_ops++;
    @(negedge clk);
    chk("ops_done", 32'(ops_done), 32'(exp_ops));
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  vec_t vecs[8];

  initial begin
    bit ok;
    int cnt[NUM_REQ];
    int total;
    int g;
    int n;

    vecs[0] = '{1, 16'sd3,   16'sd2,   32'h0000_0006};
    vecs[1] = '{1, -16'sd3,  -16'sd2,  32'h0000_0006};
    vecs[2] = '{1, -16'sd3,  16'sd2,   32'hFFFF_FFFA};
    vecs[3] = '{1, 16'h7FFF, 16'h7FFF, 32'h3FFF_0001};
    vecs[4] = '{1, 16'h8000, 16'h8000, 32'h4000_0000};
    vecs[5] = '{0, 16'h8000, 16'h7FFF, 32'hC000_8000};
    vecs[6] = '{2, 16'sd100, -16'sd100, 32'hFFFF_D8F0};
    vecs[7] = '{3, 16'sd0,   16'h1234, 32'h0000_0000};

    // Reset with every requester asking
    rst_n      = 1'b0;
    req_valid  = '1;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_ops_done", 32'(ops_done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
    end
    chk("rst_product", resp_product, 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    @(posedge clk); #1;
    req_valid = '0;
    rst_n     = 1'b1;

    // Fairness: all four valid, each requester drops after its second grant
    acc_id_log.delete();
    acc_cyc_log.delete();
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt[i] = 0;
      req_a[16*i +: 16] = 16'(i * 1000 - 1500);
      req_b[16*i +: 16] = 16'(300 - i * 77);
    end
    @(posedge clk); #1;
    req_valid = '1;
    total = 0;
    n = 0;
    while (total < 8 && n < 100) begin
      @(negedge clk);
      n++;
      g = -1;
      for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) g = i;
      @(posedge clk); #1;
      if (g >= 0) begin
        total++;
        cnt[g]++;
        if (cnt[g] == 2) begin
          req_valid[g] = 1'b0;
        end else begin
          req_a[16*g +: 16] = 16'($urandom);
          req_b[16*g +: 16] = 16'($urandom);
        end
      end
    end
    if (total < 8) timeout("fair_accepts");
    req_valid = '0;
    wait_drain("fair_drain");
    exp_ops += total;
    chk("fair_count", 32'(acc_id_log.size()), 32'd8);
    for (int k = 0; k < acc_id_log.size(); k++)
      chk("fair_grant_id", 32'(acc_id_log[k]), 32'(k % NUM_REQ));
    for (int k = 1; k < acc_cyc_log.size(); k++)
      chk("fair_spacing", 32'(acc_cyc_log[k] - acc_cyc_log[k-1]), 32'd3);
    chk("fair_ops_done", 32'(ops_done), 32'(exp_ops));

    // Vector table
    for (int k = 0; k < 8; k++) run_single(vecs[k]);

    // Backpressure: response held while consumer stalls
    @(posedge clk); #1;
    resp_ready = 1'b0;
    req_a[32 +: 16] = 16'sd1234;
    req_b[32 +: 16] = -16'sd567;
    req_valid[2]    = 1'b1;
    wait_ready(2, ok);
    if (!ok) timeout("bp_accept");
    @(posedge clk); #1;
    req_valid[2]    = 1'b0;
    req_a[48 +: 16] = 16'sd5;
    req_b[48 +: 16] = 16'sd6;
    req_valid[3]    = 1'b1;
    wait_resp(ok);
    if (!ok) timeout("bp_resp");
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("bp_hold_product", resp_product, 32'hFFF5_52E2);
      chk("bp_hold_id", 32'(resp_id), 32'd2);
      chk("bp_hold_valid", 32'(resp_valid), 32'd1);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(negedge clk);
    exp_ops++;
    @(negedge clk);
    chk("bp_next_grant", 32'(req_ready), 32'b1000);
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    wait_drain("bp_drain");
    exp_ops++;
    chk("bp_ops_done", 32'(ops_done), 32'(exp_ops));

    // Reset during EXEC abandons the operation
    @(posedge clk); #1;
    req_a[16 +: 16] = 16'sd9;
    req_b[16 +: 16] = 16'sd9;
    req_valid[1]    = 1'b1;
    wait_ready(1, ok);
    if (!ok) timeout("mid_accept");
    @(posedge clk); #1;
    chk("mid_busy_exec", 32'(busy), 32'd1);
    rst_n     = 1'b0;
    req_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("mid_no_resp", 32'(resp_valid), 32'd0);
    end
    exp_ops = 0;
    chk("mid_ops_done", 32'(ops_done), 32'd0);
    @(posedge clk); #1;
    req_a[0 +: 16]  = -16'sd7;
    req_b[0 +: 16]  = 16'sd11;
    req_a[32 +: 16] = 16'sd12;
    req_b[32 +: 16] = -16'sd12;
    req_valid       = 4'b0101;
    @(negedge clk);
    chk("mid_grant_ptr0", 32'(req_ready), 32'b0001);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_ready(2, ok);
    if (!ok) timeout("mid_accept2");
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    wait_drain("mid_drain");
    exp_ops += 2;
    chk("mid_final_ops", 32'(ops_done), 32'(exp_ops));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
